// File: rtl/board_scan_if.sv
// Drawer handshake between the frame sequencer (master) and the cell-sprite
// drawer (slave): presented cell contents/address, draw request, done.
interface board_scan_if;
   logic [7:0] position;
   logic [7:0] address;
   logic       draw_req;
   logic       done;

   modport master (output position, output address, output draw_req, input done);
   modport slave  (input position, input address, input draw_req, output done);
endinterface

// File: rtl/board_scan.sv
// board_scan: walks the 16x16 board storage cell by cell, presents each cell
// to the sprite drawer and waits for its done (with a per-cell timeout).
// Optional feature macro: BOARD_SCAN_SKIP_EMPTY_EN -- when defined, cells
// reading 0x00 are skipped instead of being drawn.
module board_scan #(
   parameter int unsigned DRAW_TIMEOUT = 300
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   output logic [7:0]   ram_addr,
   input  logic [7:0]   ram_data,
   board_scan_if.master draw,
   output logic         busy,
   output logic         frame_done,
   output logic [8:0]   cells_drawn,
   output logic         timeout_err
);

   localparam logic [9:0] TIMEOUT_CNT = 10'(DRAW_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      DRAW,
      FINISH
   } state_t;

   state_t     state;
   logic [7:0] index;
   logic [9:0] draw_cnt;

   logic skip_cell;
   logic done_ok;
   logic draw_over;
   logic advance;

   // Cell skip decision, draw completion and the shared advance condition.
   always_comb begin
      skip_cell = 1'b0;
`ifdef BOARD_SCAN_SKIP_EMPTY_EN
      skip_cell = (ram_data == '0);
`else
      skip_cell = 1'b0;
`endif
      // done in the first DRAW cycle may still belong to the previous cell
      done_ok   = draw.done && (draw_cnt != 10'd1);
      draw_over = done_ok || (draw_cnt == TIMEOUT_CNT);
      advance   = ((state == LATCH) && skip_cell) || ((state == DRAW) && draw_over);
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         index         <= '0;
         draw_cnt      <= '0;
         ram_addr      <= '0;
         draw.position <= '0;
         draw.address  <= '0;
         draw.draw_req <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         cells_drawn   <= '0;
         timeout_err   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  index       <= '0;
                  ram_addr    <= '0;
                  cells_drawn <= '0;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
                  state       <= FETCH;
               end
            end
            FETCH: begin
               state <= LATCH;
            end
            LATCH: begin
               draw.position <= ram_data;
               draw.address  <= index;
               if (!skip_cell) begin
                  draw.draw_req <= 1'b1;
                  draw_cnt      <= 10'd1;
                  state         <= DRAW;
               end
            end
            DRAW: begin
               if (draw_over) begin
                  draw.draw_req <= 1'b0;
                  cells_drawn   <= cells_drawn + 9'd1;
                  if (!done_ok) begin
                     timeout_err <= 1'b1;
                  end
               end else begin
                  draw_cnt <= draw_cnt + 10'd1;
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // Advance is shared by a skipped LATCH and a completed DRAW; placed
         // after the case so its next-state assignment takes precedence.
         if (advance) begin
            if (index == 8'hFF) begin
               busy       <= 1'b0;
               frame_done <= 1'b1;
               state      <= FINISH;
            end else begin
               index    <= index + 8'd1;
               ram_addr <= index + 8'd1;
               state    <= FETCH;
            end
         end
      end
   end

endmodule

// File: tb/tb_board_scan.sv
// Self-checking bench for board_scan: synchronous-read RAM model, a drawer
// model with per-cell done latency, and a frame-level reference model.
// Honours BOARD_SCAN_SKIP_EMPTY_EN the same way as the design.
module tb_board_scan;
   localparam int TO    = 300;
   localparam int LIMIT = 20000;
`ifdef BOARD_SCAN_SKIP_EMPTY_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct {
      logic [7:0] addr;
      logic [7:0] pos;
      int         len;
   } draw_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] ram_addr;
   logic [7:0] ram_data;
   logic       busy;
   logic       frame_done;
   logic [8:0] cells_drawn;
   logic       timeout_err;

   board_scan_if bus ();

   board_scan #(.DRAW_TIMEOUT(TO)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .ram_addr    (ram_addr),
      .ram_data    (ram_data),
      .draw        (bus),
      .busy        (busy),
      .frame_done  (frame_done),
      .cells_drawn (cells_drawn),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   // board storage: synchronous read
   logic [7:0] mem [256];
   int         dly [256];   // drawer latency per cell; 0 = never done
   bit         tied = 1'b0; // done tied high
   always @(posedge clock) ram_data <= mem[ram_addr];

   // drawer: registered done, visible in DRAW cycle dly
   int   dcnt   = 0;
   logic done_r = 1'b0;
   assign bus.done = tied ? 1'b1 : done_r;
   always @(posedge clock) begin
      if (bus.draw_req === 1'b1) begin
         dcnt   <= dcnt + 1;
         done_r <= (dly[bus.address] != 0) && (dcnt + 1 == dly[bus.address] - 1);
      end else begin
         dcnt   <= 0;
         done_r <= 1'b0;
      end
   end

   // monitor: one record per draw_req high period
   draw_t draws[$];
   int    unstable = 0;
   logic  prev_req = 1'b0;
   always @(negedge clock) begin : mon
      int n;
      if (bus.draw_req === 1'b1) begin
         if (!prev_req) begin
            draws.push_back('{addr: bus.address, pos: bus.position, len: 1});
         end else begin
            n = draws.size() - 1;
            if (n >= 0) begin
               if (draws[n].addr !== bus.address || draws[n].pos !== bus.position) unstable++;
               draws[n].len = draws[n].len + 1;
            end
         end
      end
      prev_req <= bus.draw_req;
   end

   int total = 0;
   int bad   = 0;

   // frame observations and expectations
   int         fd_cycle, fd_count, busy_err, base, ubase;
   logic [8:0] cd_c1, cd_end;
   logic       te_c1, te_end;
   draw_t      exp_q[$];
   int         exp_fd;
   bit         exp_to;

   task automatic build_model();
      int cyc;
      int l;
      bit t;
      exp_q.delete();
      cyc    = 0;
      exp_to = 1'b0;
      for (int a = 0; a < 256; a++) begin
         if (!SKIP || mem[a] != 8'h00) begin
            t = !tied && (dly[a] == 0 || dly[a] > TO);
            l = tied ? 2 : (t ? TO : dly[a]);
            if (t) exp_to = 1'b1;
            exp_q.push_back('{addr: 8'(a), pos: mem[a], len: l});
            cyc += 2 + l;
         end else begin
            cyc += 2;
         end
      end
      exp_fd = cyc + 1;
   endtask

   task automatic setup_scenario(input int s);
      int r;
      for (int a = 0; a < 256; a++) begin
         mem[a] = 8'h00;
         dly[a] = 2;
      end
      tied = 1'b0;
      case (s)
         0: tied = 1'b1;
         1: begin
            mem[8'h00] = 8'h80; dly[8'h00] = 64;
            mem[8'h35] = 8'h40; dly[8'h35] = 64;
         end
         2: begin
            tied = 1'b1;
            mem[8'h10] = 8'h20; mem[8'h80] = 8'h1A; mem[8'hF0] = 8'h80;
         end
         3: begin
            mem[8'hFF] = 8'h10; dly[8'hFF] = 0;
         end
         4: begin
            mem[8'h05] = 8'h80; dly[8'h05] = TO;
            mem[8'h06] = 8'h40; dly[8'h06] = TO + 1;
         end
         default: begin
            for (int a = 0; a < 256; a++) begin
               if ($urandom_range(0, 7) == 0) begin
                  r = int'($urandom_range(0, 15));
                  case ($urandom_range(0, 5))
                     0: mem[a] = 8'h80;
                     1: mem[a] = 8'h40;
                     2: mem[a] = 8'h20;
                     3: mem[a] = 8'h10;
                     4: mem[a] = 8'h40 | 8'(r);
                     default: mem[a] = 8'h10 | 8'(r);
                  endcase
               end
               if ($urandom_range(0, 63) == 0) begin
                  case ($urandom_range(0, 2))
                     0: dly[a] = 0;
                     1: dly[a] = TO;
                     default: dly[a] = TO + 1;
                  endcase
               end else begin
                  dly[a] = int'($urandom_range(2, 12));
               end
            end
         end
      endcase
   endtask

   // drives one frame from the current negedge; returns at the cycle after FINISH
   task automatic run_frame(input bit noise);
      base     = draws.size();
      ubase    = unstable;
      fd_cycle = 0;
      fd_count = 0;
      busy_err = 0;
      cd_end   = '1;
      te_end   = 1'bx;
      start    = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      for (int c = 1; c <= LIMIT; c++) begin
         @(negedge clock);
         if (c == 1) begin
            cd_c1 = cells_drawn;
            te_c1 = timeout_err;
         end
         if (frame_done === 1'b1) begin
            fd_count++;
            fd_cycle = c;
            if (busy !== 1'b0) busy_err++;
            start = noise;   // start during FINISH must be dropped
            @(negedge clock);
            start = 1'b0;
            if (busy !== 1'b0 || frame_done !== 1'b0) busy_err++;
            cd_end = cells_drawn;
            te_end = timeout_err;
            break;
         end
         if (busy !== 1'b1) busy_err++;
         start = noise && ($urandom_range(0, 7) == 0);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      int idle_err;
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      total++;
      if ({ram_addr, bus.position, bus.address, bus.draw_req, busy, frame_done,
           cells_drawn, timeout_err} !== 30'b0)
         begin
            bad++;
            $display("FAIL reset_outputs: got ram_addr=%h pos=%h addr=%h req=%b busy=%b fd=%b cd=%0d te=%b, expected all zero",
                     ram_addr, bus.position, bus.address, bus.draw_req, busy, frame_done, cells_drawn, timeout_err);
         end
      idle_err = 0;
      repeat (4) begin
         @(negedge clock);
         if (busy !== 1'b0 || bus.draw_req !== 1'b0) idle_err++;
      end
      total++;
      if (idle_err != 0) begin
         bad++;
         $display("FAIL reset_idle: got %0d busy/draw_req cycles without start, expected 0", idle_err);
      end
   endtask

   task automatic test_frame_scan();
      int fbad;
      int g;
      for (int s = 0; s < 9; s++) begin
         setup_scenario(s);
         build_model();
         run_frame(s >= 5);

         total++;
         if (fd_cycle != exp_fd) begin
            bad++;
            $display("FAIL frame_done_cycle s%0d: got %0d expected %0d", s, fd_cycle, exp_fd);
         end
         total++;
         if (fd_count != 1) begin
            bad++;
            $display("FAIL frame_done_pulses s%0d: got %0d expected 1", s, fd_count);
         end
         total++;
         if (draws.size() - base != exp_q.size()) begin
            bad++;
            $display("FAIL draw_count s%0d: got %0d expected %0d", s, draws.size() - base, exp_q.size());
         end
         fbad = -1;
         for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i >= draws.size() || draws[base+i].addr !== exp_q[i].addr ||
                draws[base+i].pos !== exp_q[i].pos || draws[base+i].len != exp_q[i].len) begin
               fbad = i;
               break;
            end
         end
         total++;
         if (fbad >= 0) begin
            bad++;
            g = base + fbad;
            if (g < draws.size())
               $display("FAIL draw_list s%0d item%0d: got addr=%h pos=%h len=%0d expected addr=%h pos=%h len=%0d",
                        s, fbad, draws[g].addr, draws[g].pos, draws[g].len,
                        exp_q[fbad].addr, exp_q[fbad].pos, exp_q[fbad].len);
            else
               $display("FAIL draw_list s%0d item%0d: got no draw expected addr=%h pos=%h len=%0d",
                        s, fbad, exp_q[fbad].addr, exp_q[fbad].pos, exp_q[fbad].len);
         end
         total++;
         if (unstable != ubase) begin
            bad++;
            $display("FAIL draw_stable s%0d: got %0d unstable cycles expected 0", s, unstable - ubase);
         end
         total++;
         if (cd_end !== 9'(exp_q.size())) begin
            bad++;
            $display("FAIL cells_drawn s%0d: got %0d expected %0d", s, cd_end, exp_q.size());
         end
         total++;
         if (te_end !== exp_to) begin
            bad++;
            $display("FAIL timeout_err s%0d: got %b expected %b", s, te_end, exp_to);
         end
         total++;
         if (busy_err != 0) begin
            bad++;
            $display("FAIL busy s%0d: got %0d wrong cycles expected 0", s, busy_err);
         end
         total++;
         if ({cd_c1, te_c1} !== 10'b0) begin
            bad++;
            $display("FAIL start_clear s%0d: got cd=%0d te=%b expected 0/0", s, cd_c1, te_c1);
         end
      end
   endtask

   task automatic test_reset_mid_draw();
      int k;
      int idle_err;
      for (int a = 0; a < 256; a++) begin
         mem[a] = 8'h00;
         dly[a] = 0;
      end
      mem[8'h00] = 8'h80;
      tied = 1'b0;
      k = 0;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      for (int c = 0; c < 200 && k < 10; c++) begin
         @(negedge clock);
         if (bus.draw_req === 1'b1) k++;
         start = (k == 5);
         if (k == 10) reset = 1'b1;
      end
      start = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      total++;
      if (k != 10) begin
         bad++;
         $display("FAIL reach_draw10: got %0d draw cycles expected 10", k);
      end
      total++;
      if ({ram_addr, bus.position, bus.address, bus.draw_req, busy, frame_done,
           cells_drawn, timeout_err} !== 30'b0)
         begin
            bad++;
            $display("FAIL mid_draw_reset: got ram_addr=%h pos=%h addr=%h req=%b busy=%b fd=%b cd=%0d te=%b, expected all zero",
                     ram_addr, bus.position, bus.address, bus.draw_req, busy, frame_done, cells_drawn, timeout_err);
         end
      idle_err = 0;
      repeat (6) begin
         @(negedge clock);
         if (busy !== 1'b0 || bus.draw_req !== 1'b0 || ram_addr !== 8'h00) idle_err++;
      end
      total++;
      if (idle_err != 0) begin
         bad++;
         $display("FAIL no_restart: got %0d active cycles after reset expected 0", idle_err);
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         mem[a] = 8'h00;
         dly[a] = 2;
      end
      test_reset();
      test_frame_scan();
      test_reset_mid_draw();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/board_scan.md
# board_scan

Frame sequencer that walks the 16×16 board storage cell by cell and feeds each cell to the cell-sprite drawer. For every cell it reads the storage byte, presents it with its cell address on the drawer's `position`/`address` inputs, and waits for the drawer's `done` before moving on. It sits between board storage (synchronous-read RAM) and the cell drawer, and it is the initiator side of the drawer's position/address/done interface.

## Interface

Parameters:
- `DRAW_TIMEOUT`, default 300: maximum number of DRAW cycles allowed per cell; legal range 2..1023.

Ports:
- `clock`  in  1  system clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins one frame scan; sampled only in IDLE.
- `ram_addr`  out  8  storage read address; [3:0] is the column, [7:4] is the row.
- `ram_data`  in  8  storage read data; valid the cycle after `ram_addr` is driven.
- `position`  out  8  cell contents to the drawer. Codes: 0x80 wall, 0x40 tank1, 0x20 tank2, 0x10 projectile, 0x00 empty.
- `address`  out  8  cell address to the drawer, in the same format as `ram_addr`.
- `draw_req`  out  1  high while the drawer is drawing the presented cell.
- `done`  in  1  drawer finished the presented cell.
- `busy`  out  1  a frame scan is in progress.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `cells_drawn`  out  9  number of draws completed in the current or last frame.
- `timeout_err`  out  1  sticky flag: at least one draw in this frame timed out.

## Operation

- States: IDLE, FETCH, LATCH, DRAW, FINISH.
- **IDLE**
  - `start`=1: clear `cells_drawn`, `timeout_err` and the cell index; go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH** (1 cycle): `ram_addr` = cell index. Go to LATCH.
- **LATCH** (1 cycle): register `ram_data` into `position` and the index into `address`.
  - If the cell is empty (see Configuration), skip it: advance as described below.
  - Otherwise go to DRAW.
- **DRAW**
  - `draw_req`=1; `position` and `address` are held stable.
  - The draw cycle counter starts at 1 on entry.
  - `done` is ignored in the first DRAW cycle, because the drawer's `done` is registered and can still reflect the previous cell.
  - From the second cycle on, `done`=1 completes the draw: `cells_drawn`+1, then advance.
  - If the counter reaches `DRAW_TIMEOUT` without `done`, the draw also completes: `cells_drawn`+1, `timeout_err`=1, then advance.
- **Advance**
  - Index < 255: index+1, go to FETCH.
  - Index = 255: go to FINISH. The index does not wrap within a frame.
- **FINISH** (1 cycle): `frame_done`=1, `busy`=0, then go to IDLE.
- `busy` = 1 in FETCH, LATCH and DRAW.
- `start` while busy or in FINISH is ignored; it is not queued.
- `ram_data` is forwarded unmodified. Any non-empty code, including ones with direction bits set in [3:0], is presented to the drawer.
- `cells_drawn` holds its value after FINISH until the next accepted `start`.

## Timing

- Reset values: state IDLE, index 0. `ram_addr`, `position`, `address`, `draw_req`, `busy`, `frame_done`, `cells_drawn` and `timeout_err` are all 0.
- Reset takes effect at the next edge from any state, including mid-DRAW. `draw_req` is low in the cycle after the reset edge.
- Cycle numbering: `start` sampled at edge 0 → FETCH for cell 0 in cycle 1.
- Skipped cell: 2 cycles.
- Drawn cell: 2 cycles plus the DRAW length.
  - Minimum DRAW length is 2 cycles.
  - DRAW length = k when `done` is first seen in DRAW cycle k≥2.
  - DRAW length = `DRAW_TIMEOUT` on timeout.
- The next cell's FETCH is in the cycle immediately after the completing DRAW cycle.
- `draw_req` deasserts in that same next cycle.
- All-empty frame with skipping: FETCH/LATCH fill cycles 1..512, FINISH (`frame_done`) in cycle 513, IDLE in cycle 514.
- A `start` in cycle 514 is accepted.

## Configuration

- `BOARD_SCAN_SKIP_EMPTY_EN`
  - Defined: cells reading 0x00 are skipped in LATCH and never raise `draw_req`.
  - Undefined: every cell, including 0x00, goes through DRAW, so the drawer can paint background. A full frame is then always 256 draws.

## Test plan

- All-empty RAM, macro defined, `start` at edge 0 → `draw_req` never high, `frame_done` pulse in cycle 513 only, `cells_drawn`=0, `timeout_err`=0.
- Wall at 0x00 and tank1 at 0x35, drawer model asserting `done` for 1 cycle 64 cycles after `draw_req` rises → exactly two draws, (`address`,`position`) = (0x00,0x80) then (0x35,0x40), each `draw_req` 64 cycles, `cells_drawn`=2.
- `done` tied high, 3 non-empty cells → each `draw_req` lasts exactly 2 cycles (stale `done` ignored in cycle 1), `cells_drawn`=3.
- `done` tied low, projectile at 0xFF → `draw_req` high for 300 cycles, `timeout_err`=1, `frame_done` in the next cycle, `cells_drawn`=1.
- `reset` asserted on the 10th DRAW cycle, and `start` pulsed while busy → after reset, all outputs 0 and IDLE; the mid-frame `start` pulse did not restart the scan.
- Macro undefined, all-empty RAM, `done` tied high → 256 draws of `position`=0x00 with addresses 0x00..0xFF in order, `cells_drawn`=256, `frame_done` in cycle 1025.
